// File: rtl/uart_cmd_assembler.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_assembler
// Purpose  : Pairs bytes from the UART byte receiver (high byte first) into
//            16-bit commands for the command processor. A half-received
//            command is dropped if its low byte does not arrive within
//            TMO_CYCLES clocks, so the stream re-synchronises.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            rx_data, rx_rdy   - received byte and its ready level
//            clr_rx_rdy        - combinational acknowledge to the receiver
//            cmd, cmd_rdy      - registered command and its valid level
//            clr_cmd_rdy       - consumer acknowledge, clears cmd_rdy
//            frame_err         - one-cycle pulse when a high byte times out
//            overrun, clr_overrun - sticky overwrite flag and its clear
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_assembler #(
  parameter int TMO_CYCLES = 262144,
  parameter int TMO_W      = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        frame_err,
  output logic        overrun,
  input  logic        clr_overrun
);

  typedef enum logic [0:0] {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } state_t;

  localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TMO_CYCLES - 1);
  localparam logic [TMO_W-1:0] C_ONE      = TMO_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_hi;
  logic [TMO_W-1:0] r_cnt;
  logic             w_hi_cap;
  logic             w_cmd_done;
  logic             w_tmo;

  // Every byte is taken in the cycle it is presented, in either state, so
  // the acknowledge is simply the ready level. Gated by rst_n so nothing is
  // acknowledged while the block is held in reset.
  assign clr_rx_rdy = rx_rdy & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_HI;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hi_cap    = 1'b0;
    w_cmd_done  = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      WAIT_HI: begin
        if (rx_rdy) begin
          w_hi_cap    = 1'b1;
          w_state_nxt = WAIT_LO;
        end
      end
      WAIT_LO: begin
        // A byte arriving in the final timeout cycle still completes the
        // command; the timeout only fires when no byte is present.
        if (rx_rdy) begin
          w_cmd_done  = 1'b1;
          w_state_nxt = WAIT_HI;
        end else if (r_cnt == C_TMO_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = WAIT_HI;
        end
      end
      default: begin
        w_state_nxt = WAIT_HI;
      end
    endcase
  end

  // High-byte register and inter-byte timeout counter. The counter only
  // runs while a low byte is awaited and is zero on entry to WAIT_LO, so it
  // never gets past TMO_CYCLES-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi  <= 8'h00;
      r_cnt <= '0;
    end else begin
      if (w_hi_cap) begin
        r_hi <= rx_data;
      end
      if (r_state == WAIT_LO && w_state_nxt == WAIT_LO) begin
        r_cnt <= r_cnt + C_ONE;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // Command outputs. A completing command takes priority over both
  // acknowledges: cmd_rdy stays set with the new value, and an overrun that
  // coincides with clr_overrun is still recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd       <= 16'h0000;
      cmd_rdy   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= w_tmo;
      if (w_cmd_done) begin
        cmd     <= {r_hi, rx_data};
        cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
      // Overwriting a command the consumer is acknowledging in this same
      // cycle is not an overrun.
      if (w_cmd_done && cmd_rdy && !clr_cmd_rdy) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_assembler
// Purpose  : Self-checking bench for uart_cmd_assembler. Stimulus pushes the
//            expected command into a queue; an independent monitor pops and
//            compares whenever a new command appears on cmd/cmd_rdy.
//            Directed checks cover reset, handshake, timeout, boundary,
//            overrun and mid-command reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_assembler;

  localparam int TMO_CYCLES = 16;
  localparam int TMO_W      = 5;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        frame_err;
  logic        overrun;
  logic        clr_overrun;

  int checks;
  int errors;
  int fe_count;

  logic [15:0] exp_q[$];
  logic        prev_rdy;
  logic [15:0] prev_cmd;

  uart_cmd_assembler #(
    .TMO_CYCLES(TMO_CYCLES),
    .TMO_W     (TMO_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_rdy     (rx_rdy),
    .clr_rx_rdy (clr_rx_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: a new command is a rising cmd_rdy or a changed cmd while valid.
  // Stimulus never issues the same value twice in a row, so every completion
  // is visible here.
  initial begin
    prev_rdy = 1'b0;
    prev_cmd = 16'h0000;
  end

  always @(negedge clk) begin
    if (rst_n && cmd_rdy && (!prev_rdy || cmd !== prev_cmd)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cmd_unexpected actual=%0h required=none", cmd);
      end else begin
        chk("cmd_scoreboard", {16'h0, cmd}, {16'h0, exp_q.pop_front()});
      end
    end
    prev_rdy = cmd_rdy;
    prev_cmd = cmd;
  end

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_count++;
  end

  // Present one byte with rx_rdy held until acknowledged; the receiver model
  // drops rx_rdy at the capturing edge. Entered and left just after posedge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    @(negedge clk);
    chk("clr_rx_rdy_ack", {31'h0, clr_rx_rdy}, 32'h1);
    @(posedge clk);
    #1 rx_rdy = 1'b0;
    #1 chk("clr_rx_rdy_release", {31'h0, clr_rx_rdy}, 32'h0);
  endtask

  task automatic ack_cmd();
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd"},       {16'h0, cmd},        32'h0);
    chk({tag, "_cmd_rdy"},   {31'h0, cmd_rdy},    32'h0);
    chk({tag, "_frame_err"}, {31'h0, frame_err},  32'h0);
    chk({tag, "_overrun"},   {31'h0, overrun},    32'h0);
    chk({tag, "_clr_rx"},    {31'h0, clr_rx_rdy}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    fe_count    = 0;
    rst_n       = 1'b0;
    rx_data     = 8'h00;
    rx_rdy      = 1'b1;   // ready while in reset must not be acknowledged
    clr_cmd_rdy = 1'b0;
    clr_overrun = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rx_rdy = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk);
    #2;

    // Basic command 0xA53C
    send_byte(8'hA5);
    chk("no_cmd_after_hi", {31'h0, cmd_rdy}, 32'h0);
    exp_q.push_back(16'hA53C);
    send_byte(8'h3C);
    chk("a53c_rdy", {31'h0, cmd_rdy}, 32'h1);
    chk("a53c_cmd", {16'h0, cmd}, 32'hA53C);
    chk("a53c_frame_err", {31'h0, frame_err}, 32'h0);
    chk("a53c_overrun", {31'h0, overrun}, 32'h0);

    // Acknowledge clears cmd_rdy, cmd holds
    ack_cmd();
    chk("ack_rdy_cleared", {31'h0, cmd_rdy}, 32'h0);
    chk("ack_cmd_held", {16'h0, cmd}, 32'hA53C);

    // Extreme byte values are plain data
    send_byte(8'h00);
    exp_q.push_back(16'h00FF);
    send_byte(8'hFF);
    chk("00ff_rdy", {31'h0, cmd_rdy}, 32'h1);
    chk("00ff_cmd", {16'h0, cmd}, 32'h00FF);
    ack_cmd();

    // Timeout: frame_err exactly 16 cycles after high-byte capture
    send_byte(8'h12);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1 chk($sformatf("tmo_frame_err_c%0d", k), {31'h0, frame_err}, (k == 16) ? 32'h1 : 32'h0);
    end
    chk("tmo_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    chk("tmo_cmd_held", {16'h0, cmd}, 32'h00FF);
    #1;
    send_byte(8'h34);
    exp_q.push_back(16'h3456);
    send_byte(8'h56);
    chk("resync_cmd", {16'h0, cmd}, 32'h3456);
    ack_cmd();

    // Boundary: low byte presented in the cycle the counter reaches 15
    send_byte(8'hBE);
    repeat (15) @(posedge clk);
    #1;
    exp_q.push_back(16'hBEEF);
    send_byte(8'hEF);
    chk("bound_cmd", {16'h0, cmd}, 32'hBEEF);
    chk("bound_rdy", {31'h0, cmd_rdy}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 chk("bound_no_frame_err", {31'h0, frame_err}, 32'h0);
    end
    ack_cmd();

    // Overrun
    send_byte(8'h11);
    exp_q.push_back(16'h1111);
    send_byte(8'h11);
    chk("ovr_first_clean", {31'h0, overrun}, 32'h0);
    send_byte(8'h22);
    exp_q.push_back(16'h2222);
    send_byte(8'h22);
    chk("ovr_cmd", {16'h0, cmd}, 32'h2222);
    chk("ovr_set", {31'h0, overrun}, 32'h1);
    repeat (4) @(posedge clk);
    #1 chk("ovr_sticky", {31'h0, overrun}, 32'h1);
    clr_overrun = 1'b1;
    @(posedge clk);
    #1 clr_overrun = 1'b0;
    chk("ovr_cleared", {31'h0, overrun}, 32'h0);

    // Acknowledge in the completion cycle: set wins, no overrun
    send_byte(8'h33);
    exp_q.push_back(16'h3344);
    clr_cmd_rdy = 1'b1;
    send_byte(8'h44);
    clr_cmd_rdy = 1'b0;
    chk("setwin_rdy", {31'h0, cmd_rdy}, 32'h1);
    chk("setwin_cmd", {16'h0, cmd}, 32'h3344);
    chk("setwin_no_ovr", {31'h0, overrun}, 32'h0);

    // Reset between high and low byte
    send_byte(8'h77);
    rx_rdy = 1'b1;
    rst_n  = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rx_rdy = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk);
    #2;
    send_byte(8'h88);
    chk("midrst_no_cmd_yet", {31'h0, cmd_rdy}, 32'h0);
    exp_q.push_back(16'h8899);
    send_byte(8'h99);
    chk("midrst_cmd", {16'h0, cmd}, 32'h8899);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    chk("frame_err_pulses", fe_count, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_assembler.md
Name: uart_cmd_assembler

Overview:
- Sits directly downstream of the UART byte receiver.
- Consumes received bytes through the receiver's rdy/clr_rdy handshake and assembles pairs of bytes, high byte first, into 16-bit commands for the command processor.
- Drops a half-received command if the second byte does not arrive within a programmable inter-byte timeout, so the stream re-synchronises.
- Flags commands that overwrite an unconsumed command.

Parameters:
- TMO_CYCLES, 262144: inter-byte timeout in clk cycles, counted from high-byte capture. Must be at least 2. Default is about 10 byte times at 19200 baud with a 50 MHz clk.
- TMO_W, 18: width of the timeout counter. Must satisfy 2^TMO_W >= TMO_CYCLES.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  byte from the receiver; valid while rx_rdy=1.
- rx_rdy  in  1  receiver byte-ready level; held until cleared.
- clr_rx_rdy  out  1  one-cycle pulse to the receiver's clr_rdy input.
- cmd  out  16  assembled command {high byte, low byte}; registered.
- cmd_rdy  out  1  command-valid level.
- clr_cmd_rdy  in  1  consumer acknowledge; clears cmd_rdy.
- frame_err  out  1  one-cycle pulse when a timeout discards a high byte.
- overrun  out  1  sticky flag: a command completed while cmd_rdy was already 1.
- clr_overrun  in  1  clears overrun.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All state is cleared asynchronously.
  - state=WAIT_HI, high-byte register=0x00, cmd=0x0000, cmd_rdy=0, frame_err=0, overrun=0, timeout counter=0.
  - clr_rx_rdy=0 while rst_n=0.
- clr_rx_rdy is combinational: equals rx_rdy in both states, and is never asserted in any other case.
  - Each byte is therefore acknowledged in the same cycle it is captured.
  - The receiver drops rx_rdy at the next edge, so there is no double capture.
- WAIT_HI state:
  - On rx_rdy=1: latch rx_data into the high-byte register, clear the timeout counter, go to WAIT_LO.
  - cmd_rdy and cmd are unaffected; the previous command stays valid until acknowledged.
- WAIT_LO state:
  - The timeout counter increments every cycle.
  - On rx_rdy=1: at the same edge, cmd <= {high byte, rx_data} and cmd_rdy <= 1; go to WAIT_HI.
  - Latency: rx_rdy of the low byte seen in cycle N gives cmd/cmd_rdy valid from cycle N+1.
  - Timeout: when the counter reaches TMO_CYCLES-1 with rx_rdy=0, go to WAIT_HI and assert frame_err for exactly 1 cycle (the next cycle). The high byte is discarded; cmd and cmd_rdy are unchanged.
  - If rx_rdy=1 in the same cycle the counter reaches TMO_CYCLES-1, the byte wins: the command completes and there is no frame_err.
- cmd_rdy:
  - Cleared at the edge following clr_cmd_rdy=1.
  - If clr_cmd_rdy=1 in the same cycle a command completes, set wins: cmd_rdy=1 with the new cmd.
  - clr_cmd_rdy while cmd_rdy=0 has no effect.
- overrun:
  - Set when a command completes while cmd_rdy=1 and clr_cmd_rdy=0. The new cmd overwrites the old one.
  - Stays set until clr_overrun=1.
  - If set and clear occur in the same cycle, set wins.
- Counter arithmetic:
  - The timeout counter is unsigned, TMO_W bits.
  - It is held at 0 in WAIT_HI and never wraps, because it resets before reaching TMO_CYCLES.
- Byte values: no byte value has special meaning. 0x00 and 0xFF are ordinary data.
- Reset mid-command: asynchronous reset in WAIT_LO discards the high byte. The next byte received is treated as a high byte.

Test Plan:
- Reset, then bytes 0xA5 and 0x3C each presented with rx_rdy held until clr_rx_rdy → clr_rx_rdy pulses 1 cycle per byte; cmd=0xA53C and cmd_rdy=1 one cycle after the second byte; frame_err=0, overrun=0.
- clr_cmd_rdy pulse after the command above → cmd_rdy=0 next cycle; cmd holds 0xA53C. Then send 0x00, 0xFF → cmd=0x00FF, cmd_rdy=1.
- Timeout, with TMO_CYCLES=16: send 0x12, then nothing for 20 cycles → frame_err high for exactly 1 cycle, 16 cycles after high-byte capture; then 0x34, 0x56 → cmd=0x3456 (0x12 discarded).
- Boundary, with TMO_CYCLES=16: low byte's rx_rdy arrives exactly in the cycle the counter reaches 15 → command completes, no frame_err.
- Overrun: two full commands 0x1111 then 0x2222 with no clr_cmd_rdy → cmd=0x2222, overrun=1 and stays 1. clr_overrun → overrun=0. clr_cmd_rdy asserted in the completion cycle → cmd_rdy remains 1.
- Assert rst_n=0 between the high byte 0x77 and the low byte → all outputs return to reset values; then 0x88, 0x99 → cmd=0x8899.
